// File: rtl/lsu_split_unit.sv
// Memory-stage load/store unit: one request at a time over a word-indexed RAM
// port. Bus-word-crossing accesses are issued as two beats.
module lsu_split_unit #(
  parameter int          DATA_W         = 64,
  parameter logic [63:0] BASE_ADDR      = 64'h8000_0000,
  parameter bit          ALLOW_MISALIGN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [4:0]        req_rd,
  output logic              mem_req,
  input  logic              mem_ack,
  output logic              mem_wen,
  output logic [DATA_W-1:0] mem_idx,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_wmask,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [4:0]        resp_rd,
  output logic              misalign_err,
  output logic              busy
);
  localparam int B  = DATA_W / 8;
  localparam int LB = $clog2(B);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;
  state_t state, state_nxt;

  logic              wen_q, uns_q, split_q;
  logic [1:0]        size_q;
  logic [LB-1:0]     off_q;
  logic [DATA_W-1:0] idx0_q, wdata_q, lo_q, hi_q;

  // split decision on the incoming request, before anything is latched
  logic [LB+1:0] end_now;
  logic          split_now, accept, reject;
  assign end_now   = (LB+2)'(req_addr[LB-1:0]) + ((LB+2)'(1) << req_size);
  assign split_now = end_now > (LB+2)'(B);
  assign accept    = req_valid && (state == IDLE);
  assign reject    = accept && split_now && !ALLOW_MISALIGN;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept && !reject) state_nxt = BEAT0;
      BEAT0: if (mem_ack) state_nxt = split_q ? BEAT1 : RESP;
      BEAT1: if (mem_ack) state_nxt = RESP;
      RESP:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wen_q <= 1'b0; uns_q <= 1'b0; split_q <= 1'b0; size_q <= '0; off_q <= '0;
      idx0_q <= '0; wdata_q <= '0; lo_q <= '0; hi_q <= '0;
      resp_rd <= '0; misalign_err <= 1'b0;
    end else begin
      misalign_err <= reject;
      if (accept) begin
        wen_q   <= req_wen;
        uns_q   <= req_unsigned;
        size_q  <= req_size;
        off_q   <= req_addr[LB-1:0];
        split_q <= split_now;
        idx0_q  <= (req_addr - BASE_ADDR[DATA_W-1:0]) >> LB;
        wdata_q <= req_wdata;
        resp_rd <= req_rd;
        hi_q    <= '0;
      end
      if (state == BEAT0 && mem_ack) lo_q <= mem_rdata;
      if (state == BEAT1 && mem_ack) hi_q <= mem_rdata;
    end
  end

  // Double-width lane vectors: beat 0 drives the low half, beat 1 the high half
  logic [2*DATA_W-1:0] wide_w, wide_m, wide_r;
  logic [2*B-1:0]      bmask;
  always_comb begin
    wide_w = {{DATA_W{1'b0}}, wdata_q} << {off_q, 3'b000};
    bmask  = ~({(2*B){1'b1}} << (4'd1 << size_q)) << off_q;
    for (int b = 0; b < 2*B; b++) wide_m[8*b +: 8] = {8{bmask[b]}};
    wide_r = {hi_q, lo_q} >> {off_q, 3'b000};
  end

  logic [DATA_W-1:0] rlow, keep, ext;
  logic              sgn;
  always_comb begin
    rlow = wide_r[DATA_W-1:0];
    keep = '1;
    sgn  = 1'b0;
    case (size_q)
      2'd0: begin keep = DATA_W'(8'hFF);   sgn = rlow[7];  end
      2'd1: begin keep = DATA_W'(16'hFFFF); sgn = rlow[15]; end
      2'd2: if (DATA_W > 32) begin keep = DATA_W'(32'hFFFF_FFFF); sgn = rlow[31]; end
      default: ;
    endcase
    ext = (rlow & keep) | ((sgn && !uns_q) ? ~keep : '0);
  end

  always_comb begin
    mem_req    = 1'b0;
    mem_wen    = 1'b0;
    mem_idx    = '0;
    mem_wdata  = '0;
    mem_wmask  = '0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    req_ready  = (state == IDLE);
    busy       = (state != IDLE);
    case (state)
      BEAT0: begin
        mem_req   = 1'b1;
        mem_wen   = wen_q;
        mem_idx   = idx0_q;
        mem_wdata = wide_w[DATA_W-1:0];
        mem_wmask = wide_m[DATA_W-1:0];
      end
      BEAT1: begin
        mem_req   = 1'b1;
        mem_wen   = wen_q;
        mem_idx   = idx0_q + DATA_W'(1);
        mem_wdata = wide_w[2*DATA_W-1:DATA_W];
        mem_wmask = wide_m[2*DATA_W-1:DATA_W];
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_rdata = wen_q ? '0 : ext;
      end
      default: ;
    endcase
  end
endmodule
